mmu_rx_bd_rsp: RTL

Receiving end of the mmu_tx → mmu_rx BD stream. Accepts 512-bit single-beat BDs and queues their serial numbers in arrival order. It collects out-of-order DDR write-done events from the kernel-side write path and returns in-order `wr_ddr_rsp_en`/`wr_ddr_rsp_sn` feedback to mmu_tx. It also enforces an online-BD credit limit, which it reports through `online_feedback_en`.

---
 rtl/mmu_rx_bd_rsp.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/mmu_rx_bd_rsp.sv
// ---------------------------------------------------------------------------
// mmu_rx_bd_rsp
//
// Purpose:
//   Receiving end of the mmu_tx -> mmu_rx BD stream. Single-beat 512-bit BDs
//   are accepted and their serial numbers (SN) are queued in arrival order.
//   Out-of-order DDR write-done events are recorded in a 2048-entry bitmap.
//   A small response FSM returns in-order wr_ddr_rsp_en / wr_ddr_rsp_sn
//   feedback to mmu_tx. The number of BDs in flight ("online") is limited by
//   a programmable credit limit.
//
// Ports:
//   clk_sys, rst                 single clock, synchronous active-high reset
//   bd2rx_m_axis_*               BD stream in (SN in tdata[10:0], tkeep ignored)
//   ddr_wr_done, ddr_wr_done_sn  one-cycle completion pulse + SN
//   wr_ddr_rsp_en, wr_ddr_rsp_sn in-order response pulse + SN
//   online_feedback_en           registered "online count below limit"
//   reg_mmu_rx_online_beat       online BD limit (0 blocks acceptance)
//   mmu_rx_online_beat           current online count
//   rx_bd_sta                    response FSM state (0 IDLE, 1 WAIT, 2 RSP)
//   rx_bd_err                    sticky error (malformed BD / duplicate done)
//
// Configuration:
//   MMU_RX_BD_DFX_EN  when defined, adds 32-bit wrapping debug counters
//                     rx_bd_cnt, rx_rsp_cnt and rx_drop_cnt as output ports.
// ---------------------------------------------------------------------------
module mmu_rx_bd_rsp #(
    parameter int unsigned      A_DTH      = 9,
    parameter logic [A_DTH-1:0] FULL_LEVEL = 9'd400
) (
    input  logic         clk_sys,
    input  logic         rst,
    input  logic [511:0] bd2rx_m_axis_tdata,
    input  logic [63:0]  bd2rx_m_axis_tkeep,
    input  logic         bd2rx_m_axis_tlast,
    input  logic         bd2rx_m_axis_tvalid,
    output logic         bd2rx_m_axis_tready,
    input  logic         ddr_wr_done,
    input  logic [10:0]  ddr_wr_done_sn,
    output logic         wr_ddr_rsp_en,
    output logic [10:0]  wr_ddr_rsp_sn,
    output logic         online_feedback_en,
    input  logic [10:0]  reg_mmu_rx_online_beat,
    output logic [10:0]  mmu_rx_online_beat,
    output logic [1:0]   rx_bd_sta,
    output logic         rx_bd_err
`ifdef MMU_RX_BD_DFX_EN
    ,
    output logic [31:0]  rx_bd_cnt,
    output logic [31:0]  rx_rsp_cnt,
    output logic [31:0]  rx_drop_cnt
`endif
);

    localparam int unsigned DEPTH = 1 << A_DTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [10:0]       fifo_mem [DEPTH];
    logic [A_DTH-1:0]  wr_ptr;
    logic [A_DTH-1:0]  rd_ptr;
    logic [A_DTH:0]    fifo_cnt;
    logic [10:0]       head_sn;

    logic [2047:0]     done_map;
    logic [10:0]       online_cnt;
    logic              fb_reg;
    logic              drop_mode;

    logic              beat_acc;
    logic              push;
    logic              pop;
    logic              drop_beat;
    logic              head_hit;
    logic              dup_done;

    // tkeep and the BD payload above the SN carry nothing this block needs.
    logic              unused_bits;
    assign unused_bits = ^{bd2rx_m_axis_tkeep, bd2rx_m_axis_tdata[511:11]};

    // ------------------------------------------------------------------
    // Acceptance and classification of incoming beats
    // ------------------------------------------------------------------
    assign bd2rx_m_axis_tready = ~rst
                               & (fifo_cnt < {1'b0, FULL_LEVEL})
                               & (online_cnt < reg_mmu_rx_online_beat);

    assign beat_acc  = bd2rx_m_axis_tvalid & bd2rx_m_axis_tready;
    // Once a multi-beat (malformed) BD is seen, everything through its
    // closing tlast beat is thrown away.
    assign drop_beat = beat_acc & (drop_mode | ~bd2rx_m_axis_tlast);
    assign push      = beat_acc & bd2rx_m_axis_tlast & ~drop_mode;
    assign pop       = (state == S_RSP);

    assign head_sn   = fifo_mem[rd_ptr];

    // Bypass lets a done that arrives in the same cycle as the WAIT check
    // count as a hit without waiting for the bitmap write.
    assign head_hit  = done_map[head_sn]
                     | (ddr_wr_done & (ddr_wr_done_sn == head_sn));
    assign dup_done  = ddr_wr_done & done_map[ddr_wr_done_sn];

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            drop_mode <= 1'b0;
        end else if (beat_acc) begin
            if (drop_mode) begin
                drop_mode <= ~bd2rx_m_axis_tlast;
            end else if (!bd2rx_m_axis_tlast) begin
                drop_mode <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            rx_bd_err <= 1'b0;
        end else if (dup_done || (beat_acc && !bd2rx_m_axis_tlast)) begin
            rx_bd_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending-SN FIFO (storage is not reset; pointers and count are)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bd2rx_m_axis_tdata[10:0];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write-done bitmap
    // ------------------------------------------------------------------
    // A duplicate done leaves the bit alone. The RSP clear is written last
    // so it wins if the same SN is both reported and retired this cycle.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            done_map <= '0;
        end else begin
            if (ddr_wr_done && !done_map[ddr_wr_done_sn]) begin
                done_map[ddr_wr_done_sn] <= 1'b1;
            end
            if (pop) begin
                done_map[head_sn] <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Online credit count and feedback
    // ------------------------------------------------------------------
    // push is only possible below the limit, so the count cannot overshoot.
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            online_cnt <= '0;
        end else begin
            case ({push, pop})
                2'b10:   online_cnt <= online_cnt + 1'b1;
                2'b01:   online_cnt <= online_cnt - 1'b1;
                default: online_cnt <= online_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            fb_reg <= 1'b0;
        end else begin
            fb_reg <= (online_cnt < reg_mmu_rx_online_beat);
        end
    end

    assign online_feedback_en = fb_reg & ~rst;
    assign mmu_rx_online_beat = online_cnt;

    // ------------------------------------------------------------------
    // Response FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (fifo_cnt != '0) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (head_hit) begin
                    state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                // Occupancy after this pop: still something left, or a new
                // BD landing in the same cycle.
                if ((fifo_cnt != {{A_DTH{1'b0}}, 1'b1}) || push) begin
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ddr_rsp_en = 1'b0;
        wr_ddr_rsp_sn = '0;
        if (state == S_RSP) begin
            wr_ddr_rsp_en = 1'b1;
            wr_ddr_rsp_sn = head_sn;
        end
    end

    assign rx_bd_sta = state;

`ifdef MMU_RX_BD_DFX_EN
    // ------------------------------------------------------------------
    // Debug counters (wrap silently)
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            rx_bd_cnt   <= '0;
            rx_rsp_cnt  <= '0;
            rx_drop_cnt <= '0;
        end else begin
            if (push) begin
                rx_bd_cnt <= rx_bd_cnt + 1'b1;
            end
            if (pop) begin
                rx_rsp_cnt <= rx_rsp_cnt + 1'b1;
            end
            if (drop_beat) begin
                rx_drop_cnt <= rx_drop_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = drop_beat;
`endif

endmodule
